// File: rtl/imm_encode_if.sv
// imm_encode_if
//   Bundles the word-in / word-out handshake of imm_encode.
//   Input side : in_valid, in_ready, imm[31:0], imm_src[1:0], base[31:0]
//   Output side: out_valid, out_ready, instr[31:0], out_err, err_count[7:0]
//   master: the environment that offers words and consumes results.
//   slave : the encoder block itself.
interface imm_encode_if;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] imm;
   logic [1:0]  imm_src;
   logic [31:0] base;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] instr;
   logic        out_err;
   logic [7:0]  err_count;

   modport master (
      output in_valid, imm, imm_src, base, out_ready,
      input  in_ready, out_valid, instr, out_err, err_count
   );

   modport slave (
      input  in_valid, imm, imm_src, base, out_ready,
      output in_ready, out_valid, instr, out_err, err_count
   );
endinterface

// File: rtl/imm_encode.sv
// imm_encode
//   Two-stage pipelined immediate packer. Inserts a signed 32-bit immediate
//   into the bit positions owned by the selected instruction format
//   (00 I, 01 S, 10 B, 11 J); all other bits come from the base template.
//   Immediates the format cannot hold raise out_err; the word is still packed
//   from the truncated bits and delivered. err_count counts handed-off
//   erroneous words and saturates at 255.
// Ports
//   clk   : rising-edge clock
//   reset : synchronous, active-high reset
//   bus   : imm_encode_if.slave (valid/ready in, valid/ready out, err_count)
module imm_encode (
   input  logic        clk,
   input  logic        reset,
   imm_encode_if.slave bus
);
   localparam logic [1:0] FMT_I = 2'b00;
   localparam logic [1:0] FMT_S = 2'b01;
   localparam logic [1:0] FMT_B = 2'b10;
   localparam logic [1:0] FMT_J = 2'b11;

   // stage 1: raw operands
   logic        s1_valid_reg;
   logic [31:0] s1_imm_reg;
   logic [1:0]  s1_src_reg;
   logic [31:0] s1_base_reg;

   // stage 2: packed result
   logic        s2_valid_reg;
   logic [31:0] s2_instr_reg;
   logic        s2_err_reg;

   logic [7:0]  err_count_reg;

   logic        s2_load;
   logic        s1_load;
   logic        out_fire;
   logic [31:0] instr_next;
   logic        err_next;

   // Arithmetic right shifts collapse the high immediate bits to 0 or all
   // ones exactly when they are a pure sign extension of the bit below.
   logic [31:0] sh11;
   logic [31:0] sh12;
   logic [31:0] sh20;
   logic        fits11;
   logic        fits12;
   logic        fits20;

   assign sh11   = $unsigned($signed(s1_imm_reg) >>> 11);
   assign sh12   = $unsigned($signed(s1_imm_reg) >>> 12);
   assign sh20   = $unsigned($signed(s1_imm_reg) >>> 20);
   assign fits11 = (sh11 == 32'h0000_0000) || (sh11 == 32'hFFFF_FFFF);
   assign fits12 = (sh12 == 32'h0000_0000) || (sh12 == 32'hFFFF_FFFF);
   assign fits20 = (sh20 == 32'h0000_0000) || (sh20 == 32'hFFFF_FFFF);

   // Stage 2 frees up when empty or when its word is taken this cycle;
   // stage 1 frees up when empty or when it moves into stage 2. The input
   // side is ready exactly when stage 1 can load, which reduces to
   // !s1_valid || !s2_valid || out_ready (combinational from out_ready).
   assign s2_load      = !s2_valid_reg || bus.out_ready;
   assign s1_load      = !s1_valid_reg || s2_load;
   assign out_fire     = s2_valid_reg && bus.out_ready;

   assign bus.in_ready  = s1_load;
   assign bus.out_valid = s2_valid_reg;
   assign bus.instr     = s2_instr_reg;
   assign bus.out_err   = s2_err_reg;
   assign bus.err_count = err_count_reg;

   always_comb begin
      instr_next = s1_base_reg;
      err_next   = 1'b0;
      unique case (s1_src_reg)
         FMT_I: begin
            instr_next[31:20] = s1_imm_reg[11:0];
            err_next          = !fits11;
         end
         FMT_S: begin
            instr_next[31:25] = s1_imm_reg[11:5];
            instr_next[11:7]  = s1_imm_reg[4:0];
            err_next          = !fits11;
         end
         FMT_B: begin
            instr_next[31]    = s1_imm_reg[12];
            instr_next[30:25] = s1_imm_reg[10:5];
            instr_next[11:8]  = s1_imm_reg[4:1];
            instr_next[7]     = s1_imm_reg[11];
            err_next          = !fits12 || s1_imm_reg[0];
         end
         FMT_J: begin
            instr_next[31]    = s1_imm_reg[20];
            instr_next[30:21] = s1_imm_reg[10:1];
            instr_next[20]    = s1_imm_reg[11];
            instr_next[19:12] = s1_imm_reg[19:12];
            err_next          = !fits20 || s1_imm_reg[0];
         end
         default: begin
            instr_next = s1_base_reg;
            err_next   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         s1_valid_reg  <= 1'b0;
         s1_imm_reg    <= '0;
         s1_src_reg    <= '0;
         s1_base_reg   <= '0;
         s2_valid_reg  <= 1'b0;
         s2_instr_reg  <= '0;
         s2_err_reg    <= 1'b0;
         err_count_reg <= '0;
      end else begin
         if (s1_load) begin
            s1_valid_reg <= bus.in_valid;
            if (bus.in_valid) begin
               s1_imm_reg  <= bus.imm;
               s1_src_reg  <= bus.imm_src;
               s1_base_reg <= bus.base;
            end
         end
         if (s2_load) begin
            s2_valid_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
               s2_instr_reg <= instr_next;
               s2_err_reg   <= err_next;
            end
         end
         if (out_fire && s2_err_reg && (err_count_reg != 8'hFF)) begin
            err_count_reg <= err_count_reg + 8'd1;
         end
      end
   end
endmodule
